pool2x2_act: RTL



---
 rtl/pool2x2_act.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pool2x2_act.sv
// pool2x2_act: 2x2 stride-2 pooling (max or average) with optional ReLU over a
// raster-order, multi-channel feature map.
//
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   soft_clr   - synchronous frame abort (wins over valid_in)
//   mode       - 0 = max pool, 1 = average pool (latched on first beat of frame)
//   relu_en    - 1 = clamp negative results to 0 (latched on first beat of frame)
//   valid_in   - data_in carries one pixel this cycle
//   data_in    - NUM_CH packed signed samples, channel 0 in the LSBs
//   data_out   - NUM_CH packed pooled results, same packing as data_in
//   valid_out  - one-cycle pulse per completed 2x2 window
//   frame_done - pulses together with the last valid_out of a frame
module pool2x2_act #(
    parameter int DATA_W    = 12,
    parameter int NUM_CH    = 3,
    parameter int IN_WIDTH  = 24,
    parameter int IN_HEIGHT = 24,
    parameter int COL_W     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     soft_clr,
    input  logic                     mode,
    input  logic                     relu_en,
    input  logic                     valid_in,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic                     valid_out,
    output logic                     frame_done
);

    localparam int PAIRS = IN_WIDTH / 2;
    localparam int OROWS = IN_HEIGHT / 2;
    localparam int ROW_W = (OROWS > 1) ? $clog2(OROWS) : 1;
    localparam int ACC_W = DATA_W + 2;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(PAIRS - 1);
    localparam logic [ROW_W-1:0] OROW_LAST = ROW_W'(OROWS - 1);

    typedef logic signed [ACC_W-1:0] acc_t;

    // Running partial result per pair column and channel; not reset because
    // the even-row, even-column write always overwrites an entry before use.
    acc_t lbuf_q [PAIRS][NUM_CH];

    logic                     px_q, px_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic                     row_par_q, row_par_d;
    logic [ROW_W-1:0]         orow_q, orow_d;
    logic                     mode_q, mode_d;
    logic                     relu_q, relu_d;
    logic [NUM_CH*DATA_W-1:0] data_out_q, data_out_d;
    logic                     valid_out_q, valid_out_d;
    logic                     frame_done_q, frame_done_d;

    logic                     first_beat;
    logic                     mode_eff;
    logic                     relu_eff;
    logic                     window_end;
    logic                     lbuf_we;
    acc_t                     samp_ext   [NUM_CH];
    acc_t                     combined   [NUM_CH];
    acc_t                     lbuf_wdata [NUM_CH];
    logic [DATA_W-1:0]        res_ch     [NUM_CH];

    function automatic acc_t combine(input acc_t a, input acc_t b, input logic avg);
        if (avg) begin
            return a + b;
        end
        return (a > b) ? a : b;
    endfunction

    always_comb begin
        // On the first beat of a frame the live inputs act as the latched
        // values, so pixel (0,0) is already processed in the new mode.
        first_beat = ~px_q & ~row_par_q & (col_q == '0) & (orow_q == '0);
        mode_eff   = first_beat ? mode    : mode_q;
        relu_eff   = first_beat ? relu_en : relu_q;
        window_end = row_par_q & px_q;
        lbuf_we    = valid_in & ~soft_clr & ~window_end;

        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            samp_ext[ch] = {{2{data_in[ch*DATA_W + DATA_W - 1]}}, data_in[ch*DATA_W +: DATA_W]};
            combined[ch] = combine(lbuf_q[col_q][ch], samp_ext[ch], mode_eff);
            lbuf_wdata[ch] = (~row_par_q & ~px_q) ? samp_ext[ch] : combined[ch];
            res_ch[ch] = mode_eff ? DATA_W'(combined[ch] >>> 2) : combined[ch][DATA_W-1:0];
            if (relu_eff && res_ch[ch][DATA_W-1]) begin
                res_ch[ch] = '0;
            end
        end

        px_d         = px_q;
        col_d        = col_q;
        row_par_d    = row_par_q;
        orow_d       = orow_q;
        mode_d       = mode_q;
        relu_d       = relu_q;
        data_out_d   = data_out_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;

        if (soft_clr) begin
            px_d      = 1'b0;
            col_d     = '0;
            row_par_d = 1'b0;
            orow_d    = '0;
            mode_d    = 1'b0;
            relu_d    = 1'b0;
        end else if (valid_in) begin
            mode_d = mode_eff;
            relu_d = relu_eff;
            px_d   = ~px_q;
            if (px_q) begin
                if (col_q == COL_LAST) begin
                    col_d     = '0;
                    row_par_d = ~row_par_q;
                    if (row_par_q) begin
                        orow_d = (orow_q == OROW_LAST) ? '0 : orow_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            if (window_end) begin
                valid_out_d  = 1'b1;
                frame_done_d = (col_q == COL_LAST) && (orow_q == OROW_LAST);
                for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                    data_out_d[ch*DATA_W +: DATA_W] = res_ch[ch];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_q         <= 1'b0;
            col_q        <= '0;
            row_par_q    <= 1'b0;
            orow_q       <= '0;
            mode_q       <= 1'b0;
            relu_q       <= 1'b0;
            data_out_q   <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            px_q         <= px_d;
            col_q        <= col_d;
            row_par_q    <= row_par_d;
            orow_q       <= orow_d;
            mode_q       <= mode_d;
            relu_q       <= relu_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (lbuf_we) begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                lbuf_q[col_q][ch] <= lbuf_wdata[ch];
            end
        end
    end

    assign data_out   = data_out_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;

endmodule
